// File: rtl/mmio_irq_pkg.sv
// mmio_irq_pkg
//   Shared definitions for the memory-mapped timer / interrupt source:
//   register offsets within the window, CTRL field positions, and the
//   packed CTRL register type with a helper that formats it for readback.
package mmio_irq_pkg;

    // Byte offsets of the five registers inside the window.
    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_LOAD   = 5'h04;
    localparam logic [4:0] OFF_COUNT  = 5'h08;
    localparam logic [4:0] OFF_STATUS = 5'h0C;
    localparam logic [4:0] OFF_SWINT  = 5'h10;

    // CTRL bit positions.
    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_AUTO_BIT = 1;
    localparam int unsigned CTRL_SEL_LSB  = 8;

    localparam int unsigned NUM_IRQ = 8;

    typedef struct packed {
        logic [2:0] sel;
        logic       auto;
        logic       en;
    } ctrl_t;

    // Place the CTRL fields at their architectural bit positions.
    function automatic logic [31:0] ctrl_to_word(ctrl_t c);
        logic [31:0] w;
        w                      = '0;
        w[CTRL_EN_BIT]         = c.en;
        w[CTRL_AUTO_BIT]       = c.auto;
        w[CTRL_SEL_LSB +: 3]   = c.sel;
        return w;
    endfunction

endpackage

// File: rtl/mmio_irq_timer_if.sv
// mmio_irq_timer_if
//   Data-memory bus between the core and the timer block.
//   memwrite/dataadr/writedata : core -> timer write strobe, byte address, data
//   hit/readdata               : timer -> core address match and read data
//   master modport: core side; slave modport: timer side.
interface mmio_irq_timer_if;

    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        hit;
    logic [31:0] readdata;

    modport master (
        output memwrite,
        output dataadr,
        output writedata,
        input  hit,
        input  readdata
    );

    modport slave (
        input  memwrite,
        input  dataadr,
        input  writedata,
        output hit,
        output readdata
    );

endinterface

// File: rtl/irq_pulse_stretcher.sv
// irq_pulse_stretcher
//   Turns a single-cycle trigger into a PulseLen-cycle high output.
//   A trigger while the pulse is active restarts the count (no accumulation).
//   clk_i   : clock, posedge
//   rst_i   : asynchronous active-high reset
//   trig_i  : one-cycle trigger
//   pulse_o : high while the internal counter is nonzero
module irq_pulse_stretcher #(
    parameter int unsigned PulseLen = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic trig_i,
    output logic pulse_o
);

    localparam logic [7:0] LenVal = 8'(PulseLen);

    logic [7:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (trig_i) begin
            cnt_d = LenVal;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pulse_o = (cnt_q != 8'd0);

endmodule

// File: rtl/mmio_irq_timer.sv
// mmio_irq_timer
//   Memory-mapped countdown timer and software interrupt source on the MIPS
//   data-memory write bus. Drives the core's interrupts[7:0] from the timer
//   pending flag (routed to line SEL) and per-line software pulses.
//   ph1        : sole clock, posedge
//   reset      : asynchronous active-high reset
//   bus        : slave side of the data-memory bus (write, address, read, hit)
//   interrupts : registered active-high interrupt lines to the core
//   Map: 0x00 CTRL{SEL[10:8],AUTO[1],EN[0]}, 0x04 LOAD, 0x08 COUNT (RO),
//        0x0C STATUS{PEND[0]} W1C, 0x10 SWINT[7:0] write-only.
module mmio_irq_timer
    import mmio_irq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF0000,
    parameter int unsigned PULSE_LEN = 5,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                   ph1,
    input  logic                   reset,
    mmio_irq_timer_if.slave        bus,
    output logic [NUM_IRQ-1:0]     interrupts
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [4:0]  off;
    logic        hit;
    logic        wr;
    logic        wr_ctrl, wr_load, wr_status, wr_swint;
    logic [31:0] wd;

    assign off = bus.dataadr[4:0];
    assign wd  = bus.writedata;

    // Only the five aligned register slots match; 0x14-0x1C and misaligned
    // addresses fall outside the window.
    assign hit = (bus.dataadr[31:5] == BASE_ADDR[31:5]) &&
                 (off[1:0] == 2'b00) && (off <= OFF_SWINT);

    assign wr        = bus.memwrite & hit;
    assign wr_ctrl   = wr && (off == OFF_CTRL);
    assign wr_load   = wr && (off == OFF_LOAD);
    assign wr_status = wr && (off == OFF_STATUS);
    assign wr_swint  = wr && (off == OFF_SWINT);

    // ------------------------------------------------------------------
    // Register file and timer
    // ------------------------------------------------------------------
    ctrl_t              ctrl_d, ctrl_q;
    logic [CNT_W-1:0]   load_d, load_q;
    logic [CNT_W-1:0]   count_d, count_q;
    logic               pend_d, pend_q;
    logic               expire;

    always_comb begin
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;
        expire  = 1'b0;

        // CTRL write never touches COUNT.
        if (wr_ctrl) begin
            ctrl_d.en   = wd[CTRL_EN_BIT];
            ctrl_d.auto = wd[CTRL_AUTO_BIT];
            ctrl_d.sel  = wd[CTRL_SEL_LSB +: 3];
        end

        if (wr_load) begin
            load_d  = wd[CNT_W-1:0];
            count_d = wd[CNT_W-1:0];
        end else if (ctrl_q.en && (count_q > CntOne)) begin
            count_d = count_q - CntOne;
        end else if (ctrl_q.en && (count_q == CntOne)) begin
            // Reloading on the COUNT==1 cycle gives a period of exactly LOAD.
            expire  = 1'b1;
            count_d = ctrl_q.auto ? load_q : '0;
            // A same-cycle CTRL write keeps the EN value software wrote.
            if (!ctrl_q.auto && !wr_ctrl) begin
                ctrl_d.en = 1'b0;
            end
        end
        // EN with COUNT==0 idles; LOAD=0 therefore never fires.
    end

    // Expiry beats a same-cycle write-1-to-clear.
    assign pend_d = expire | (pend_q & ~(wr_status & wd[0]));

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            ctrl_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            pend_q  <= pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Software pulses
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] pulse;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_pulse
        irq_pulse_stretcher #(
            .PulseLen (PULSE_LEN)
        ) u_stretch (
            .clk_i   (ph1),
            .rst_i   (reset),
            .trig_i  (wr_swint & wd[i]),
            .pulse_o (pulse[i])
        );
    end

    // ------------------------------------------------------------------
    // Interrupt output stage
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] interrupts_d, interrupts_q;

    always_comb begin
        interrupts_d = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            interrupts_d[i] = (pend_q && (ctrl_q.sel == i[2:0])) || pulse[i];
        end
    end

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            interrupts_q <= '0;
        end else begin
            interrupts_q <= interrupts_d;
        end
    end

    assign interrupts = interrupts_q;

    // ------------------------------------------------------------------
    // Read mux (COUNT returns the pre-update value)
    // ------------------------------------------------------------------
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                OFF_CTRL:   rdata = ctrl_to_word(ctrl_q);
                OFF_LOAD:   rdata[CNT_W-1:0] = load_q;
                OFF_COUNT:  rdata[CNT_W-1:0] = count_q;
                OFF_STATUS: rdata[0] = pend_q;
                default:    rdata = '0;
            endcase
        end
    end

    assign bus.hit      = hit;
    assign bus.readdata = rdata;

endmodule
